seg_readback: RTL and testbench

// - Receiving end of the two-digit multiplexed 7-segment interface (seg_code/seg_code1 with scan/scan1 strobes).
// - Decodes the displayed patterns back into a binary result, sign flag and error flag.
// - Used for on-board self-check of the calculator result path; sits beside the display scanner on the same clk.

---
 rtl/seg_readback_if.sv | 21 ++
 rtl/seg_readback.sv | 146 ++++++++++++++
 tb/tb_seg_readback.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_readback_if.sv
// rtl/seg_readback_if.sv - two-digit seven-segment link between display scanner and readback checker
interface seg_readback_if;
    logic [7:0] seg_code;
    logic [7:0] seg_code1;
    logic       scan;
    logic       scan1;
    logic [7:0] value;
    logic       neg;
    logic       valid;
    logic       err;

    modport master (
        output seg_code, seg_code1, scan, scan1,
        input  value, neg, valid, err
    );

    modport slave (
        input  seg_code, seg_code1, scan, scan1,
        output value, neg, valid, err
    );
endinterface

// File: rtl/seg_readback.sv
// rtl/seg_readback.sv - decodes scanned 7-segment digits back to binary; optional hex digits via SEG_READBACK_HEX_EN
module seg_readback #(
    parameter int STABLE_CNT = 4,
    parameter int TIMEOUT    = 200000
) (
    input logic           clk,
    input logic           rst,
    seg_readback_if.slave bus
);
    localparam int SW = $clog2(STABLE_CNT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CNT);
    localparam logic [SW-1:0] STAB_ONE = SW'(1);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {WAIT_U, WAIT_T, CHECK} state_t;

    state_t          state;
    logic            scan_q, scan_qq, scan1_q, scan1_qq;
    logic [6:0]      cap_u, cap_t;
    logic [13:0]     prev_frame;
    logic [SW-1:0]   stab;
    logic [TW-1:0]   tcnt;
    logic            published;

    // Returns {legal, digit}; the decimal point bit never reaches here.
    function automatic logic [4:0] decode_digit(input logic [6:0] p);
        case (p)
            7'h3F:   decode_digit = {1'b1, 4'h0};
            7'h06:   decode_digit = {1'b1, 4'h1};
            7'h5B:   decode_digit = {1'b1, 4'h2};
            7'h4F:   decode_digit = {1'b1, 4'h3};
            7'h66:   decode_digit = {1'b1, 4'h4};
            7'h6D:   decode_digit = {1'b1, 4'h5};
            7'h7D:   decode_digit = {1'b1, 4'h6};
            7'h07:   decode_digit = {1'b1, 4'h7};
            7'h7F:   decode_digit = {1'b1, 4'h8};
            7'h6F:   decode_digit = {1'b1, 4'h9};
`ifdef SEG_READBACK_HEX_EN
            7'h77:   decode_digit = {1'b1, 4'hA};
            7'h7C:   decode_digit = {1'b1, 4'hB};
            7'h39:   decode_digit = {1'b1, 4'hC};
            7'h5E:   decode_digit = {1'b1, 4'hD};
            7'h79:   decode_digit = {1'b1, 4'hE};
            7'h71:   decode_digit = {1'b1, 4'hF};
`endif
            default: decode_digit = 5'h00;
        endcase
    endfunction

    logic          scan_rise, scan1_rise;
    logic [4:0]    u_dec, t_dec;
    logic          t_minus, t_blank, frame_ok, same_frame, publish;
    logic [3:0]    t_digit;
    logic [7:0]    new_value;
    logic [SW-1:0] stab_next;

    assign scan_rise  = scan_q & ~scan_qq;
    assign scan1_rise = scan1_q & ~scan1_qq;

    always_comb begin
        u_dec      = decode_digit(cap_u);
        t_dec      = decode_digit(cap_t);
        t_minus    = (cap_t == 7'h40);
        t_blank    = (cap_t == 7'h00);
        frame_ok   = u_dec[4] && (t_dec[4] || t_minus || t_blank);
        t_digit    = t_dec[4] ? t_dec[3:0] : 4'd0;
`ifdef SEG_READBACK_HEX_EN
        new_value  = {t_digit, u_dec[3:0]};
`else
        new_value  = ({4'd0, t_digit} * 8'd10) + {4'd0, u_dec[3:0]};
`endif
        same_frame = ({cap_t, cap_u} == prev_frame);
        stab_next  = same_frame ? ((stab == STAB_MAX) ? STAB_MAX : stab + STAB_ONE) : STAB_ONE;
        // Re-publishing an unchanged value is suppressed once something has been reported.
        publish    = frame_ok && (stab_next == STAB_MAX) &&
                     (!published || (new_value != bus.value) || (t_minus != bus.neg));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= WAIT_U;
            scan_q     <= 1'b0;
            scan_qq    <= 1'b0;
            scan1_q    <= 1'b0;
            scan1_qq   <= 1'b0;
            cap_u      <= '0;
            cap_t      <= '0;
            prev_frame <= '0;
            stab       <= '0;
            tcnt       <= '0;
            published  <= 1'b0;
            bus.value  <= '0;
            bus.neg    <= 1'b0;
            bus.valid  <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            scan_q    <= bus.scan;
            scan_qq   <= scan_q;
            scan1_q   <= bus.scan1;
            scan1_qq  <= scan1_q;
            bus.valid <= 1'b0;
            if (state == CHECK) begin
                tcnt  <= '0;
                state <= WAIT_U;
                if (!frame_ok) begin
                    bus.err <= 1'b1;
                    stab    <= '0;
                end else begin
                    stab       <= stab_next;
                    prev_frame <= {cap_t, cap_u};
                    if (publish) begin
                        bus.value <= new_value;
                        bus.neg   <= t_minus;
                        bus.valid <= 1'b1;
                        bus.err   <= 1'b0;
                        published <= 1'b1;
                    end
                end
            end else if (tcnt == T_LAST) begin
                tcnt    <= '0;
                bus.err <= 1'b1;
                stab    <= '0;
                state   <= WAIT_U;
            end else begin
                tcnt <= tcnt + TW'(1);
                if (state == WAIT_U) begin
                    // A tens strobe arriving together with the units strobe is dropped here.
                    if (scan_rise) begin
                        cap_u <= bus.seg_code[6:0];
                        state <= WAIT_T;
                    end
                end else begin
                    if (scan_rise) begin
                        cap_u <= bus.seg_code[6:0];
                    end
                    if (scan1_rise) begin
                        cap_t <= bus.seg_code1[6:0];
                        tcnt  <= '0;
                        state <= CHECK;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_seg_readback.sv
// tb/tb_seg_readback.sv - randomized and directed self-check of seg_readback against a digit-level model
module tb_seg_readback;
    localparam int STAB = 4;
    localparam int TOUT = 300;
`ifdef SEG_READBACK_HEX_EN
    localparam int NDIG = 16;
    localparam int BASE = 16;
`else
    localparam int NDIG = 10;
    localparam int BASE = 10;
`endif

    logic clk = 1'b0;
    logic rst;
    seg_readback_if bus ();

    seg_readback #(.STABLE_CNT(STAB), .TIMEOUT(TOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          m_val;
    logic        m_neg, m_err, m_pub;
    int          m_run;
    logic [13:0] m_last;

    function automatic logic [6:0] pat_of(input int d);
        case (d)
            0: pat_of = 7'h3F;  1: pat_of = 7'h06;  2: pat_of = 7'h5B;  3: pat_of = 7'h4F;
            4: pat_of = 7'h66;  5: pat_of = 7'h6D;  6: pat_of = 7'h7D;  7: pat_of = 7'h07;
            8: pat_of = 7'h7F;  9: pat_of = 7'h6F;  10: pat_of = 7'h77; 11: pat_of = 7'h7C;
            12: pat_of = 7'h39; 13: pat_of = 7'h5E; 14: pat_of = 7'h79; default: pat_of = 7'h71;
        endcase
    endfunction

    function automatic int digit_of(input logic [6:0] p);
        digit_of = -1;
        for (int d = 0; d < NDIG; d++)
            if (pat_of(d) == p) digit_of = d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_val = 0; m_neg = 0; m_err = 0; m_pub = 0; m_run = 0; m_last = '0;
    endtask

    task automatic model_frame(input logic [7:0] u, input logic [7:0] t, output logic pulse);
        int du, dt, nv;
        logic mn, same;
        pulse = 1'b0;
        du = digit_of(u[6:0]);
        mn = (t[6:0] == 7'h40);
        dt = (t[6:0] == 7'h00 || mn) ? 0 : digit_of(t[6:0]);
        if (du < 0 || dt < 0) begin
            m_err = 1'b1;
            m_run = 0;
        end else begin
            same   = (m_run > 0) && ({t[6:0], u[6:0]} == m_last);
            m_run  = same ? ((m_run + 1 > STAB) ? STAB : m_run + 1) : 1;
            m_last = {t[6:0], u[6:0]};
            nv     = dt * BASE + du;
            if (m_run == STAB && (!m_pub || nv != m_val || mn != m_neg)) begin
                m_val = nv; m_neg = mn; m_err = 1'b0; m_pub = 1'b1; pulse = 1'b1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_value"}, 32'(bus.value), 32'(m_val));
        check({tag, "_neg"},   32'(bus.neg),   32'(m_neg));
        check({tag, "_err"},   32'(bus.err),   32'(m_err));
    endtask

    task automatic send_frame(input logic [7:0] u, input logic [7:0] t, input string tag);
        logic exp_pulse;
        int pulses, at;
        model_frame(u, t, exp_pulse);
        @(negedge clk);
        bus.seg_code = u;
        bus.scan     = 1'b1;
        repeat (3) @(negedge clk);
        bus.scan = 1'b0;
        repeat (2) @(negedge clk);
        bus.seg_code1 = t;
        bus.scan1     = 1'b1;
        pulses = 0;
        at     = -1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid) begin
                pulses++;
                at = i;
            end
        end
        bus.scan1 = 1'b0;
        check({tag, "_pulses"}, 32'(pulses), exp_pulse ? 32'd1 : 32'd0);
        if (exp_pulse) check({tag, "_latency"}, 32'(at), 32'd2);
        check_outputs(tag);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] u, t;
        logic [7:0] pu, pt;

        rst = 1'b0;
        bus.seg_code = '0; bus.seg_code1 = '0; bus.scan = 1'b0; bus.scan1 = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_value", 32'(bus.value), 32'd0);
        check("rst_neg",   32'(bus.neg),   32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_err",   32'(bus.err),   32'd0);
        rst = 1'b1;

        repeat (4) send_frame(8'h5B, 8'h06, "twelve");
        check("twelve_literal", 32'(bus.value), 32'd12);

        send_frame(8'h00, 8'h06, "blank_units");
        check("blank_units_err", 32'(bus.err), 32'd1);

        // Reset between the units and tens strobes of a frame.
        @(negedge clk);
        bus.seg_code = 8'h06;
        bus.scan     = 1'b1;
        repeat (3) @(negedge clk);
        bus.scan = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_value", 32'(bus.value), 32'd0);
        check("midrst_neg",   32'(bus.neg),   32'd0);
        check("midrst_valid", 32'(bus.valid), 32'd0);
        check("midrst_err",   32'(bus.err),   32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (4) send_frame(8'h06, 8'h5B, "after_rst");

        repeat (4) send_frame(8'h3F, 8'h00, "zero_blank");
        repeat (4) send_frame(8'h4F, 8'h40, "minus_three");
        check("minus_three_literal", 32'({bus.neg, bus.value}), 32'h103);

        repeat (4) send_frame(8'h77, 8'h06, "hex_a");
`ifdef SEG_READBACK_HEX_EN
        check("hex_a_literal", 32'(bus.value), 32'h1A);
`else
        check("hex_a_literal", 32'(bus.err), 32'd1);
`endif

        for (int i = 0; i < 8; i++)
            send_frame((i % 2 == 0) ? 8'h06 : 8'h5B, 8'h00, "alternate");

        repeat (4) send_frame(8'h3F, 8'h3F, "pre_timeout");
        repeat (250) @(negedge clk);
        check("no_timeout_yet", 32'(bus.err), 32'd0);
        repeat (60) @(negedge clk);
        m_err = 1'b1;
        m_run = 0;
        check("timeout_err", 32'(bus.err), 32'd1);
        repeat (4) send_frame(8'h6F, 8'h6F, "ninety_nine");
        check("ninety_nine_literal", 32'({bus.err, bus.value}), 32'd99);

        pu = 8'h3F;
        pt = 8'h00;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 99) < 65) begin
                u = pu;
                t = pt;
            end else begin
                if ($urandom_range(0, 9) == 0)
                    u = {1'b0, pat_of($urandom_range(10, 15))};
                else if ($urandom_range(0, 19) == 0)
                    u = 8'h00;
                else
                    u = {1'b0, pat_of($urandom_range(0, 9))};
                case ($urandom_range(0, 5))
                    0:       t = 8'h00;
                    1:       t = 8'h40;
                    default: t = {1'b0, pat_of($urandom_range(0, 9))};
                endcase
            end
            u[7] = 1'($urandom_range(0, 1));
            t[7] = 1'($urandom_range(0, 1));
            pu = u;
            pt = t;
            send_frame(u, t, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
